axi_lite_initiator: RTL and testbench

- Bridges the core's native memory port (valid/ready, addr/wdata/wstrb/rdata) onto a 32-bit AXI4-lite initiator port with five channels: AW, W, B, AR, R.
- Sits between the core and the AXI memory model or interconnect.
- One transaction in flight. AW and W complete independently in either order.
- A per-transaction watchdog flags responders that never answer.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_watchdog.sv | 43 ++++
 rtl/axi_lite_initiator.sv | 143 ++++++++++++++
 tb/tb_axi_lite_initiator.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared state encoding and AXI4-lite constants
package axi_lite_pkg;

  localparam int STATE_W    = 3;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [2:0] AXI_PROT_INSN = 3'b100;
  localparam logic [2:0] AXI_PROT_DATA = 3'b000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/axi_lite_watchdog.sv
// rtl/axi_lite_watchdog.sv - saturating per-transaction cycle counter with sticky timeout flag
module axi_lite_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 timeout_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Flag rises on the edge the count reaches the limit, not one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if ((TIMEOUT_CYCLES != 0) && enable && !clear && (count_d >= LIMIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/axi_lite_initiator.sv
// rtl/axi_lite_initiator.sv - native valid/ready memory port to AXI4-lite initiator, one transaction in flight
module axi_lite_initiator
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        timeout
);

  state_e                state_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_DATA_W-1:0] wdata_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [3:0]            wstrb_q;
  logic [2:0]            arprot_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, mem_ready_q;
  logic                  accept;

  // mem_valid is still high during the mem_ready pulse, so that cycle must not re-accept.
  assign accept = (state_q == ST_IDLE) && mem_valid && !mem_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wstrb_q     <= '0;
      arprot_q    <= AXI_PROT_DATA;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= mem_addr;
            if (mem_wstrb == 4'b0000) begin
              arprot_q  <= mem_instr ? AXI_PROT_INSN : AXI_PROT_DATA;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end else begin
              wdata_q   <= mem_wdata;
              wstrb_q   <= mem_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (mem_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (mem_axi_rvalid) begin
            rdata_q     <= mem_axi_rdata;
            mem_ready_q <= mem_valid;
            rready_q    <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (mem_axi_awready) awvalid_q <= 1'b0;
          if (mem_axi_wready)  wvalid_q  <= 1'b0;
          // Both channels are finished once neither is left waiting after this edge.
          if ((!awvalid_q || mem_axi_awready) && (!wvalid_q || mem_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (mem_axi_bvalid) begin
            mem_ready_q <= mem_valid;
            bready_q    <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state_q != ST_IDLE),
    .timeout(timeout)
  );

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = AXI_PROT_DATA;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = arprot_q;
  assign mem_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// tb/tb_axi_lite_initiator.sv - self-checking bench for axi_lite_initiator
module tb_axi_lite_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready, timeout;
  logic [31:0] awaddr, wdata, araddr, rdata = 32'hBAD0BAD0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  int checks = 0, failures = 0;
  int cyc = 0, mr_cnt = 0, mr_cyc = 0, ar_rise_cyc = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] sb [$];
  logic [31:0] last_rd = '0;

  // responder controls and captured payloads
  int   aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
  bit   rand_delays = 0, ar_never = 0, aw_cap = 0, w_cap = 0;
  logic [31:0] aw_addr_cap = '0, w_data_cap = '0, ar_addr_cap = '0;
  logic [3:0]  w_strb_cap = '0;
  logic [2:0]  ar_prot_cap = '0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;
  logic [2:0]  p_arprot = '0;

  axi_lite_initiator #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
    .mem_axi_bready(bready), .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid),
    .mem_axi_rready(rready), .mem_axi_rdata(rdata), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // AXI memory responder plus handshake-stability checker, all acting on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = 32'hBAD0BAD0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0; aw_cap = 0; w_cap = 0;
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      if (p_awv && !p_awr) begin
        checks++;
        if (!(awvalid === 1'b1 && awaddr === p_awaddr && awprot === 3'b000)) begin
          failures++;
          $display("FAIL aw_stable awvalid=%b awaddr=%h awprot=%b expected 1 %h 000", awvalid, awaddr, awprot, p_awaddr);
        end
      end
      if (p_wv && !p_wr) begin
        checks++;
        if (!(wvalid === 1'b1 && wdata === p_wdata && wstrb === p_wstrb)) begin
          failures++;
          $display("FAIL w_stable wvalid=%b wdata=%h wstrb=%b expected 1 %h %b", wvalid, wdata, wstrb, p_wdata, p_wstrb);
        end
      end
      if (p_arv && !p_arr) begin
        checks++;
        if (!(arvalid === 1'b1 && araddr === p_araddr && arprot === p_arprot)) begin
          failures++;
          $display("FAIL ar_stable arvalid=%b araddr=%h arprot=%b expected 1 %h %b", arvalid, araddr, arprot, p_araddr, p_arprot);
        end
      end
      if (arvalid && !p_arv) ar_rise_cyc = cyc;

      if (awvalid && !awready) begin
        if (aw_cnt >= aw_dly) begin
          awready = 1; aw_addr_cap = awaddr; aw_cap = 1; aw_hs++;
          if (rand_delays) aw_dly = $urandom_range(0, 4);
        end else aw_cnt++;
      end else begin awready = 0; aw_cnt = 0; end

      if (wvalid && !wready) begin
        if (w_cnt >= w_dly) begin
          wready = 1; w_data_cap = wdata; w_strb_cap = wstrb; w_cap = 1; w_hs++;
          if (rand_delays) w_dly = $urandom_range(0, 4);
        end else w_cnt++;
      end else begin wready = 0; w_cnt = 0; end

      if (bready && !bvalid) begin
        if (b_cnt >= b_dly) begin
          bvalid = 1; b_hs++;
          checks++;
          if (!(aw_cap && w_cap)) begin
            failures++;
            $display("FAIL bready_early aw_done=%b w_done=%b expected 1 1", aw_cap, w_cap);
          end
          for (int b = 0; b < 4; b++)
            if (w_strb_cap[b]) mem[aw_addr_cap[9:2]][8*b +: 8] = w_data_cap[8*b +: 8];
          aw_cap = 0; w_cap = 0;
          if (rand_delays) b_dly = $urandom_range(0, 4);
        end else b_cnt++;
      end else begin bvalid = 0; b_cnt = 0; end

      if (arvalid && !arready && !ar_never) begin
        if (ar_cnt >= ar_dly) begin
          arready = 1; ar_addr_cap = araddr; ar_prot_cap = arprot; ar_hs++;
          if (rand_delays) ar_dly = $urandom_range(0, 4);
        end else ar_cnt++;
      end else begin arready = 0; ar_cnt = 0; end

      if (rready && !rvalid) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1; rdata = mem[ar_addr_cap[9:2]];
          if (rand_delays) r_dly = $urandom_range(0, 4);
        end else r_cnt++;
      end else begin rvalid = 0; r_cnt = 0; rdata = 32'hBAD0BAD0; end

      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arprot = arprot;
    end
  end

  // Completion monitor: pops the scoreboard on every mem_ready pulse.
  initial begin
    bit prev_mr = 0;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (reset) prev_mr = 0;
      else if (mem_ready) begin
        mr_cnt++; mr_cyc = cyc;
        checks++;
        if (prev_mr) begin
          failures++;
          $display("FAIL mem_ready_pulse mem_ready high two cycles in a row, expected single pulse");
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_empty unexpected mem_ready with rdata=%h", mem_rdata);
        end else begin
          exp = sb.pop_front();
          if (mem_rdata !== exp) begin
            failures++;
            $display("FAIL mem_rdata got=%h expected=%h", mem_rdata, exp);
          end
        end
        prev_mr = 1;
      end else prev_mr = 0;
    end
  end

  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins, input bit keep, output int lat);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    if (s == 4'b0000) last_rd = ref_mem[a[9:2]];
    else for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    sb.push_back(last_rd);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!mem_ready && lat < 200);
    if (!mem_ready) begin
      checks++; failures++;
      $display("FAIL txn_bound addr=%h no mem_ready after %0d cycles", a, lat);
    end
    if (!keep) mem_valid = 0;
  endtask

  task automatic apply_reset;
    reset = 1; mem_valid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    sb.delete(); last_rd = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, mem_ready, timeout} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b expected=0000000", {awvalid, wvalid, bready, arvalid, rready, mem_ready, timeout});
    end
    checks++;
    if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h expected=00000000", mem_rdata); end
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, mem_ready} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b expected=0000", {awvalid, wvalid, arvalid, mem_ready});
    end
  endtask

  task automatic test_read;
    int lat;
    int mr0 = mr_cnt;
    logic [2:0] prot_seen = '0;
    fork
      do_txn(32'h40, 32'h0, 4'b0000, 1'b1, 1'b0, lat);
      begin @(negedge clk); prot_seen = arprot; end
    join
    checks++;
    if (lat != 3) begin failures++; $display("FAIL read_latency got=%0d expected=3", lat); end
    checks++;
    if (prot_seen !== 3'b100) begin failures++; $display("FAIL read_arprot got=%b expected=100", prot_seen); end
    repeat (3) @(negedge clk);
    checks++;
    if (mr_cnt - mr0 != 1) begin failures++; $display("FAIL read_pulses got=%0d expected=1", mr_cnt - mr0); end
  endtask

  task automatic test_write;
    int lat;
    int mr0 = mr_cnt;
    logic wv = 1'b1, av = 1'b0;
    w_dly = 0; aw_dly = 3;
    fork
      do_txn(32'h100, 32'hDEADBEEF, 4'b0101, 1'b0, 1'b0, lat);
      begin repeat (2) @(negedge clk); wv = wvalid; av = awvalid; end
    join
    aw_dly = 0;
    checks++;
    if ({wv, av} !== 2'b01) begin failures++; $display("FAIL w_before_aw wvalid,awvalid=%b expected=01", {wv, av}); end
    checks++;
    if (lat != 6) begin failures++; $display("FAIL write_latency got=%0d expected=6", lat); end
    checks++;
    if (mem[64] !== 32'h00AD00EF) begin failures++; $display("FAIL write_mem got=%h expected=00ad00ef", mem[64]); end
    repeat (3) @(negedge clk);
    checks++;
    if (mr_cnt - mr0 != 1) begin failures++; $display("FAIL write_pulses got=%0d expected=1", mr_cnt - mr0); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, first_mr;
    int ar0 = ar_hs, mr0 = mr_cnt;
    do_txn(32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, lat1);
    first_mr = cyc;
    do_txn(32'h4, 32'h0, 4'b0000, 1'b0, 1'b0, lat2);
    repeat (3) @(negedge clk);
    checks++;
    if (ar_hs - ar0 != 2) begin failures++; $display("FAIL b2b_ar_count got=%0d expected=2", ar_hs - ar0); end
    checks++;
    if (ar_rise_cyc <= first_mr) begin
      failures++;
      $display("FAIL b2b_ar_gap second arvalid at cycle %0d, first mem_ready at %0d, expected later", ar_rise_cyc, first_mr);
    end
    checks++;
    if (mr_cnt - mr0 != 2) begin failures++; $display("FAIL b2b_pulses got=%0d expected=2", mr_cnt - mr0); end
  endtask

  task automatic test_reset_mid_write;
    int lat;
    aw_dly = 5; w_dly = 5;
    mem_valid = 1; mem_addr = 32'h80; mem_wdata = 32'hCAFEF00D; mem_wstrb = 4'hF; mem_instr = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (awvalid !== 1'b1) begin failures++; $display("FAIL mid_wr_awvalid got=%b expected=1", awvalid); end
    reset = 1;
    #1;
    checks++;
    if ({awvalid, wvalid, mem_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_drop awvalid,wvalid,mem_ready=%b expected=000", {awvalid, wvalid, mem_ready});
    end
    mem_valid = 0; mem_wstrb = 0;
    repeat (2) @(negedge clk);
    reset = 0; sb.delete(); last_rd = '0;
    aw_dly = 0; w_dly = 0;
    checks++;
    if (mem[32] !== ref_mem[32]) begin failures++; $display("FAIL aborted_write mem=%h expected=%h", mem[32], ref_mem[32]); end
    do_txn(32'h40, 32'h0, 4'b0000, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL post_reset_read_latency got=%0d expected=3", lat); end
  endtask

  task automatic test_timeout;
    int n = 0;
    apply_reset();
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_reset got=%b expected=0", timeout); end
    ar_never = 1;
    mem_valid = 1; mem_addr = 32'h40; mem_wstrb = 0; mem_instr = 0;
    last_rd = ref_mem[16]; sb.push_back(last_rd);
    repeat (8) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_cycle8 got=%b expected=0", timeout); end
    @(negedge clk);
    checks++;
    if ({timeout, arvalid} !== 2'b11) begin
      failures++;
      $display("FAIL timeout_cycle9 timeout,arvalid=%b expected=11", {timeout, arvalid});
    end
    ar_never = 0;
    while (!mem_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!mem_ready) begin failures++; $display("FAIL timeout_completion no mem_ready after %0d cycles", n); end
    mem_valid = 0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b expected=1", timeout); end
  endtask

  task automatic test_random;
    int lat, errs = 0, first_bad = -1;
    logic [31:0] a, d;
    logic [3:0]  s;
    rand_delays = 1;
    for (int i = 0; i < 1000; i++) begin
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      do_txn(a, d, s, 1'($urandom_range(0, 1)), 1'b0, lat);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_delays = 0; aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin errs++; if (first_bad < 0) first_bad = i; end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL random_mem %0d words differ, first word %0d got=%h expected=%h",
               errs, first_bad, mem[first_bad], ref_mem[first_bad]);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL random_sb %0d completions missing, expected 0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[16] = 32'h12345678; ref_mem[16] = 32'h12345678;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_write();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
